// File: rtl/ppc_nand_pkg.sv
// ============================================================================
// ppc_nand_pkg : register map, NFCR/INTSR bit positions for ppc_nand_regif
// Rev 1.0
// ============================================================================
`default_nettype none

package ppc_nand_pkg;

    localparam int REG_NFADDR0 = 32'h800;
    localparam int REG_NFCR    = 32'h801;
    localparam int REG_ID      = 32'h802;
    localparam int REG_STATUS  = 32'h803;
    localparam int REG_NFADDR1 = 32'h804;
    localparam int REG_VALID   = 32'h805;
    localparam int REG_NFECC0  = 32'h806;
    localparam int REG_INTSR   = 32'h807;
    localparam int REG_INTEN   = 32'h808;
    localparam int REG_WDTCNT  = 32'h809;
    localparam int PAGE_BASE   = 32'h400;

    localparam int NFCR_OP_LO  = 0;
    localparam int NFCR_PS_LO  = 4;
    localparam int NFCR_WDTEN  = 6;
    localparam int NFCR_START  = 7;
    localparam int NFCR_CE_LO  = 8;

    localparam int INT_DONE    = 0;
    localparam int INT_TIMEOUT = 1;
    localparam int INT_BUSYERR = 2;
    localparam int INT_W       = 3;

    localparam logic [31:0] UNMAPPED_VAL = 32'hFFFF_0000;

    // Registers that must not change under a running command.
    function automatic logic is_busy_guarded(input logic [31:0] idx);
        return (idx == REG_NFCR) || (idx == REG_NFADDR0) || (idx == REG_NFADDR1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppc_nand_wdt.sv
// ============================================================================
// ppc_nand_wdt : command watchdog counter with clear, enable and timeout flag
// Rev 1.0
// ============================================================================
`default_nettype none

module ppc_nand_wdt #(
    parameter int WDT_LIMIT = 1000000,
    parameter int CNT_W     = $clog2(WDT_LIMIT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             chk_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign timeout_o = en_i & chk_i & (cnt_q == CNT_W'(WDT_LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/ppc_nand_regif.sv
// ============================================================================
// ppc_nand_regif : PowerPC EBI slave for NAND controller registers and page RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ppc_nand_regif
    import ppc_nand_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int PAGE_WORDS = 512,
    parameter int NUM_CE     = 4,
    parameter int WDT_LIMIT  = 1000000,
    parameter int CE_W       = (NUM_CE > 1) ? $clog2(NUM_CE) : 1,
    parameter int RAM_AW     = $clog2(PAGE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  rd_wr,
    input  logic [DATA_W/8-1:0]   we_n,
    input  logic [ADDR_W-1:0]     ebi_addr,
    input  logic [DATA_W-1:0]     ebi_data_i,
    output logic [DATA_W-1:0]     ebi_data_o,
    output logic                  ebi_data_oe,
    input  logic [DATA_W-1:0]     id,
    input  logic [DATA_W-1:0]     valid,
    input  logic [DATA_W-1:0]     nfecc0,
    input  logic [7:0]            status,
    input  logic                  done,
    output logic                  start,
    output logic                  wdt_en,
    output logic [1:0]            page_size,
    output logic [3:0]            operate,
    output logic [CE_W-1:0]       ce_sel,
    output logic [DATA_W-1:0]     nfaddr0,
    output logic [DATA_W-1:0]     nfaddr1,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  irq
);

    localparam int BE_W  = DATA_W / 8;
    localparam int WDT_W = $clog2(WDT_LIMIT) + 1;

    logic              bus_we, bus_re, we_p, in_win;
    logic [31:0]       idx;
    logic [RAM_AW-1:0] win_off;
    logic              unused_addr_lsb;

    logic              we_o_q;
    logic [DATA_W-1:0] nfaddr0_q, nfaddr0_d, nfaddr1_q, nfaddr1_d;
    logic              start_q, start_d, wdt_en_q, wdt_en_d;
    logic [1:0]        ps_q, ps_d;
    logic [3:0]        op_q, op_d;
    logic [CE_W-1:0]   ce_q, ce_d;
    logic [INT_W-1:0]  intsr_q, intsr_d, inten_q, inten_d;
    logic [INT_W-1:0]  intsr_set, intsr_clr;
    logic              irq_q;
    logic              ram_we_q;
    logic [BE_W-1:0]   ram_be_q;
    logic [DATA_W-1:0] ram_wdata_q, nfcr_word, rdata;
    logic [RAM_AW-1:0] ram_addr_q;

    logic              guarded_wr, busy_err, done_evt, to_evt, wdt_timeout;
    logic              page_wr;
    logic [WDT_W-1:0]  wdt_cnt;

    assign bus_we  = ~cs_n & ~rd_wr & (we_n != {BE_W{1'b1}});
    assign bus_re  = ~cs_n &  rd_wr & (we_n == {BE_W{1'b1}});
    assign we_p    = bus_we & ~we_o_q;
    assign idx     = 32'(ebi_addr[ADDR_W-1:2]);
    assign in_win  = (idx >= PAGE_BASE) && (idx < PAGE_BASE + PAGE_WORDS);
    assign win_off = RAM_AW'(idx - PAGE_BASE);
    assign page_wr = we_p & in_win;
    assign unused_addr_lsb = ^ebi_addr[1:0];

    ppc_nand_wdt #(
        .WDT_LIMIT (WDT_LIMIT),
        .CNT_W     (WDT_W)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~start_q),
        .en_i      (start_q),
        .chk_i     (wdt_en_q),
        .cnt_o     (wdt_cnt),
        .timeout_o (wdt_timeout)
    );

    always_comb begin
        nfaddr0_d  = nfaddr0_q;
        nfaddr1_d  = nfaddr1_q;
        start_d    = start_q;
        wdt_en_d   = wdt_en_q;
        ps_d       = ps_q;
        op_d       = op_q;
        ce_d       = ce_q;
        inten_d    = inten_q;
        intsr_clr  = '0;

        guarded_wr = we_p & is_busy_guarded(idx);
        busy_err   = guarded_wr & start_q;
        done_evt   = done & start_q;
        // A coincident done takes precedence over the watchdog.
        to_evt     = wdt_timeout & ~done_evt;

        if (guarded_wr && !start_q) begin
            if (idx == REG_NFADDR0) nfaddr0_d = ebi_data_i;
            if (idx == REG_NFADDR1) nfaddr1_d = ebi_data_i;
            if (idx == REG_NFCR) begin
                start_d  = ebi_data_i[NFCR_START];
                wdt_en_d = ebi_data_i[NFCR_WDTEN];
                ps_d     = ebi_data_i[NFCR_PS_LO +: 2];
                op_d     = ebi_data_i[NFCR_OP_LO +: 4];
                ce_d     = ebi_data_i[NFCR_CE_LO +: CE_W];
            end
        end
        if (done_evt || wdt_timeout) begin
            start_d = 1'b0;
        end

        if (we_p && (idx == REG_INTEN)) inten_d   = ebi_data_i[INT_W-1:0];
        if (we_p && (idx == REG_INTSR)) intsr_clr = ebi_data_i[INT_W-1:0];

        intsr_set              = '0;
        intsr_set[INT_DONE]    = done_evt;
        intsr_set[INT_TIMEOUT] = to_evt;
        intsr_set[INT_BUSYERR] = busy_err;
        intsr_d = (intsr_q & ~intsr_clr) | intsr_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_o_q      <= 1'b0;
            nfaddr0_q   <= '0;
            nfaddr1_q   <= '0;
            start_q     <= 1'b0;
            wdt_en_q    <= 1'b0;
            ps_q        <= '0;
            op_q        <= '0;
            ce_q        <= '0;
            intsr_q     <= '0;
            inten_q     <= '0;
            irq_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            ram_addr_q  <= '0;
        end else begin
            we_o_q    <= bus_we;
            nfaddr0_q <= nfaddr0_d;
            nfaddr1_q <= nfaddr1_d;
            start_q   <= start_d;
            wdt_en_q  <= wdt_en_d;
            ps_q      <= ps_d;
            op_q      <= op_d;
            ce_q      <= ce_d;
            intsr_q   <= intsr_d;
            inten_q   <= inten_d;
            irq_q     <= |(intsr_q & inten_q);
            ram_we_q  <= page_wr;
            if (page_wr) begin
                ram_be_q    <= ~we_n;
                ram_wdata_q <= ebi_data_i;
                ram_addr_q  <= win_off;
            end
        end
    end

    always_comb begin
        nfcr_word                       = '0;
        nfcr_word[NFCR_OP_LO +: 4]      = op_q;
        nfcr_word[NFCR_PS_LO +: 2]      = ps_q;
        nfcr_word[NFCR_WDTEN]           = wdt_en_q;
        nfcr_word[NFCR_START]           = start_q;
        nfcr_word[NFCR_CE_LO +: CE_W]   = ce_q;

        rdata = DATA_W'(UNMAPPED_VAL);
        case (idx)
            REG_NFADDR0: rdata = nfaddr0_q;
            REG_NFCR:    rdata = nfcr_word;
            REG_ID:      rdata = id;
            REG_STATUS:  rdata = DATA_W'(status);
            REG_NFADDR1: rdata = nfaddr1_q;
            REG_VALID:   rdata = valid;
            REG_NFECC0:  rdata = nfecc0;
            REG_INTSR:   rdata = DATA_W'(intsr_q);
            REG_INTEN:   rdata = DATA_W'(inten_q);
            REG_WDTCNT:  rdata = DATA_W'(wdt_cnt);
            default:     if (in_win) rdata = ram_rdata;
        endcase
    end

    assign ebi_data_o  = rdata;
    assign ebi_data_oe = bus_re;

    assign start     = start_q;
    assign wdt_en    = wdt_en_q;
    assign page_size = ps_q;
    assign operate   = op_q;
    assign ce_sel    = ce_q;
    assign nfaddr0   = nfaddr0_q;
    assign nfaddr1   = nfaddr1_q;
    assign irq       = irq_q;

    // Reads steer the RAM address; otherwise hold the last captured write address.
    assign ram_re    = bus_re & in_win;
    assign ram_addr  = ram_re ? win_off : ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = ram_be_q;
    assign ram_we    = ram_we_q;

endmodule

`default_nettype wire
